// File: rtl/ab_seq_gen_if.sv
// Control bus of the A-then-B stimulus generator: run request, run parameters and run status.
// The slave modport is the generator side; the master modport is whatever launches runs.
interface ab_seq_gen_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  // Handshake: start is a request that the generator accepts only while busy=0 and done=0 (IDLE).
  // A request in any other cycle is dropped, not queued. count/gap are sampled in the accepting cycle.
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start,
    output count,
    output gap,
    input  busy,
    input  done,
    input  err_cnt
  );

  modport slave (
    input  start,
    input  count,
    input  gap,
    output busy,
    output done,
    output err_cnt
  );
endinterface

// File: rtl/ab_seq_gen.sv
// Emits `count` A-then-B sequences to the detector, separated by `gap` idle cycles, then pulses done.
// Optional ERR_CHECK_EN macro counts WAIT_Q cycles where the detector's Q stayed low.
module ab_seq_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  ab_seq_gen_if.slave       ctl,
  input  logic              q_in,
  output logic              a_out,
  output logic              b_out,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Q = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ctl.start) begin
          state_nx = (ctl.count == '0) ? DONE : SEND_A;
        end
      end
      SEND_A: state_nx = SEND_B;
      SEND_B: state_nx = WAIT_Q;
      WAIT_Q: begin
        if (rem == CNT_W'(1)) begin
          state_nx = DONE;
        end else if (gap_r == '0) begin
          state_nx = SEND_A;
        end else begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_nx = SEND_A;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Run parameters are frozen at acceptance so mid-run changes on the bus are harmless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem     <= '0;
      gap_r   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl.start) begin
            rem   <= ctl.count;
            gap_r <= ctl.gap;
          end
        end
        WAIT_Q: begin
          rem     <= rem - CNT_W'(1);
          gap_cnt <= gap_r;
        end
        GAP:     gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

  // B is always followed by WAIT_Q, so A can never directly follow B.
  assign a_out     = (state == SEND_A);
  assign b_out     = (state == SEND_B);
  assign ctl.busy  = (state == SEND_A) || (state == SEND_B) || (state == WAIT_Q) || (state == GAP);
  assign ctl.done  = (state == DONE);
  assign state_dbg = state;

`ifdef ERR_CHECK_EN
  logic [CNT_W-1:0] err_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= '0;
    end else if (state == IDLE && ctl.start) begin
      err_r <= '0;
    end else if (state == WAIT_Q && !q_in && err_r != '1) begin
      err_r <= err_r + CNT_W'(1);
    end
  end

  assign ctl.err_cnt = err_r;
`else
  logic unused_q;
  assign unused_q    = q_in;
  assign ctl.err_cnt = '0;
`endif

endmodule

// File: tb/tb_ab_seq_gen.sv
// Bench for ab_seq_gen: table of runs checked cycle by cycle against an expected-output queue,
// plus hand-written reset and mid-run abort sequences.
module tb_ab_seq_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       q_in;
  logic       a_out;
  logic       b_out;
  logic [2:0] state_dbg;

  ab_seq_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  ab_seq_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ctl       (bus.slave),
    .q_in      (q_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Expected {a_out, b_out, busy, done}, one entry per cycle after the start request.
  logic [3:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  typedef struct {
    int unsigned cnt;
    int unsigned gap;
    logic [15:0] qmiss;   // bit i set: hold Q low in the i-th WAIT_Q
    bit          noise;   // hammer start and count/gap while the run is in progress
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic        qs[$];
    int unsigned misses;
    int unsigned len;
    logic [3:0]  exp;
    logic [CNT_W-1:0] exp_err;
    misses = 0;
    exp_q.delete();
    for (int i = 0; i < int'(v.cnt); i++) begin
      exp_q.push_back(4'b1010); qs.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(4'b0110); qs.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(4'b0010); qs.push_back(~v.qmiss[i]);
      if (v.qmiss[i]) misses++;
      if (i != int'(v.cnt) - 1) begin
        for (int k = 0; k < int'(v.gap); k++) begin
          exp_q.push_back(4'b0010); qs.push_back(1'($urandom_range(0, 1)));
        end
      end
    end
    exp_q.push_back(4'b0001); qs.push_back(1'b1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'b0000); qs.push_back(1'b1);
    end
`ifdef ERR_CHECK_EN
    exp_err = (misses > 255) ? 8'hFF : CNT_W'(misses);
`else
    exp_err = '0;
`endif
    len = exp_q.size();

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.count = CNT_W'(v.cnt);
    bus.gap   = GAP_W'(v.gap);
    for (int c = 0; c < int'(len); c++) begin
      @(posedge clk); #1;
      if (v.noise && c <= int'(len) - 4) begin
        bus.start = 1'b1;
        bus.count = CNT_W'($urandom_range(0, 9));
        bus.gap   = GAP_W'($urandom_range(0, 15));
      end else begin
        bus.start = 1'b0;
      end
      q_in = qs[c];
      @(negedge clk);
      exp = exp_q.pop_front();
      check($sformatf("run n=%0d g=%0d cyc=%0d {a,b,busy,done}", v.cnt, v.gap, c + 1),
            {28'd0, a_out, b_out, bus.busy, bus.done}, {28'd0, exp});
      if (c >= int'(len) - 3) begin
        check($sformatf("run n=%0d err_cnt", v.cnt), 32'(bus.err_cnt), 32'(exp_err));
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{cnt: 1, gap: 0,  qmiss: 16'h0000, noise: 1'b0};
    vecs[1] = '{cnt: 3, gap: 2,  qmiss: 16'h0000, noise: 1'b0};
    vecs[2] = '{cnt: 4, gap: 0,  qmiss: 16'b1010, noise: 1'b0};
    vecs[3] = '{cnt: 0, gap: 3,  qmiss: 16'h0000, noise: 1'b0};
    vecs[4] = '{cnt: 2, gap: 5,  qmiss: 16'h0001, noise: 1'b1};
    vecs[5] = '{cnt: 6, gap: 1,  qmiss: 16'h003F, noise: 1'b0};
    vecs[6] = '{cnt: 2, gap: 15, qmiss: 16'h0002, noise: 1'b1};

    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.count = 8'd3;
    bus.gap   = 4'd1;
    q_in      = 1'b0;

    // Reset held with start asserted: everything quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset outputs", {28'd0, a_out, b_out, bus.busy, bus.done}, 32'd0);
      check("reset err_cnt", 32'(bus.err_cnt), 32'd0);
    end
    check("reset state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    bus.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle after reset", {28'd0, a_out, b_out, bus.busy, bus.done}, 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while in GAP of a count=5 run aborts without a done pulse.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.count = 8'd5;
    bus.gap   = 4'd3;
    q_in      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort pre GAP", {28'd0, a_out, b_out, bus.busy, bus.done}, 32'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort async outputs", {28'd0, a_out, b_out, bus.busy, bus.done}, 32'd0);
    check("abort async state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post abort quiet", {28'd0, a_out, b_out, bus.busy, bus.done}, 32'd0);
    end
    run_vec('{cnt: 2, gap: 1, qmiss: 16'h0000, noise: 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
